// File: rtl/fifo_wide_to_narrow.sv
// fifo_wide_to_narrow: buffers wide words in a DEPTH-entry circular store and
// emits them as NARROW_WIDTH-bit slices, first-word-fall-through, in either
// byte order. A single wide holding register feeds the slice mux, so total
// capacity is DEPTH+1 wide words.
// Optional build macro: FIFO_WIDE_TO_NARROW_COUNT_EN adds SLICE_COUNT, the
// number of slices currently buffered (storage plus unread holding slices).
module fifo_wide_to_narrow #(
   parameter int NARROW_WIDTH = 8,
   parameter int RATIO        = 4,
   parameter int DEPTH        = 8,
   parameter int MSB_FIRST    = 0
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic                            WRITE,
   input  logic [RATIO*NARROW_WIDTH-1:0]   DATA_IN,
   output logic                            FULL,
   input  logic                            READ,
   output logic [NARROW_WIDTH-1:0]         DATA_OUT,
   output logic                            EMPTY,
   output logic                            OVERFLOW,
   output logic                            UNDERFLOW
`ifdef FIFO_WIDE_TO_NARROW_COUNT_EN
   ,output logic [$clog2((DEPTH+1)*RATIO):0] SLICE_COUNT
`endif
);

   localparam int WW = RATIO * NARROW_WIDTH;
   localparam int AW = $clog2(DEPTH);
   localparam int IW = $clog2(RATIO);

   localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);

   // Output stage states: IDLE = holding register empty, SERVE = slices available
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SERVE = 1'b1;

   // Wide-word storage; no reset so it maps onto block RAM
   logic [WW-1:0] mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q,  count_d;
   logic          full_q,   full_d;

   logic [0:0]    state_q,  state_d;
   logic [WW-1:0] hold_q,   hold_d;
   logic [IW-1:0] idx_q,    idx_d;
   logic          empty_q,  empty_d;
   logic          ovf_q,    ovf_d;
   logic          unf_q,    unf_d;

   logic          serving;
   logic          last_slice;
   logic          consume;
   logic          push;
   logic          pop;

   logic [NARROW_WIDTH-1:0] slice_w [RATIO];
   logic [IW-1:0]           sel_w;

   // Next-state logic for storage pointers, output stage and status flags
   always_comb begin
      serving    = (state_q == ST_SERVE);
      last_slice = (idx_q == LAST_IDX);
      consume    = serving & READ;
      // A write is refused while FULL, even if a pop frees a slot this edge
      push       = WRITE & ~full_q;
      // Pop the head word straight into the holding register when it is
      // idle or its last slice is being consumed this edge (no bubble)
      pop        = (count_q != '0) & (~serving | (consume & last_slice));

      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
      full_d = (count_d == DEPTH_C);

      state_d = state_q;
      hold_d  = hold_q;
      idx_d   = idx_q;
      if (pop) begin
         state_d = ST_SERVE;
         hold_d  = mem_q[rd_ptr_q];
         idx_d   = '0;
      end else if (consume) begin
         if (last_slice) begin
            // Index and data are left alone so DATA_OUT holds while empty
            state_d = ST_IDLE;
         end else begin
            idx_d = idx_q + IW'(1);
         end
      end

      empty_d = (state_d != ST_SERVE);
      ovf_d   = WRITE & full_q;
      unf_d   = READ & empty_q;
   end

   // Storage write port
   always_ff @(posedge CLK) begin
      if (push) begin
         mem_q[wr_ptr_q] <= DATA_IN;
      end
   end

   // State registers, cleared asynchronously (also discards a half-served word)
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         state_q  <= ST_IDLE;
         hold_q   <= '0;
         idx_q    <= '0;
         empty_q  <= 1'b1;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         state_q  <= state_d;
         hold_q   <= hold_d;
         idx_q    <= idx_d;
         empty_q  <= empty_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Split the holding register into slices; slice k is bits (k+1)*NW-1:k*NW
   for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
      assign slice_w[gi] = hold_q[gi*NARROW_WIDTH +: NARROW_WIDTH];
   end

   // Index counts up in serve order; map it onto a slice position
   assign sel_w    = (MSB_FIRST != 0) ? (LAST_IDX - idx_q) : idx_q;
   assign DATA_OUT = slice_w[sel_w];

   assign FULL      = full_q;
   assign EMPTY     = empty_q;
   assign OVERFLOW  = ovf_q;
   assign UNDERFLOW = unf_q;

`ifdef FIFO_WIDE_TO_NARROW_COUNT_EN
   localparam int SCW = $clog2((DEPTH+1)*RATIO) + 1;

   logic [SCW-1:0] sc_q, sc_d;

   // Buffered slice count computed from next state so it tracks every edge
   always_comb begin
      sc_d = SCW'(count_d) * SCW'(RATIO);
      if (state_d == ST_SERVE) begin
         sc_d = sc_d + (SCW'(RATIO) - SCW'(idx_d));
      end
   end

   // Slice count register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sc_q <= '0;
      end else begin
         sc_q <= sc_d;
      end
   end

   assign SLICE_COUNT = sc_q;
`endif

endmodule

// File: tb/tb_fifo_wide_to_narrow.sv
// Directed bench for fifo_wide_to_narrow: one instance per byte order,
// driven with identical stimulus.
module tb_fifo_wide_to_narrow;

   logic        clk;
   logic        rst;
   logic        write;
   logic [31:0] data_in;
   logic        read;

   logic        full,  full_m;
   logic [7:0]  dout,  dout_m;
   logic        empty, empty_m;
   logic        ovf,   ovf_m;
   logic        unf,   unf_m;
`ifdef FIFO_WIDE_TO_NARROW_COUNT_EN
   logic [5:0]  sc,    sc_m;
`endif

   int total = 0;
   int bad   = 0;

   fifo_wide_to_narrow #(.NARROW_WIDTH(8), .RATIO(4), .DEPTH(8), .MSB_FIRST(0)) dut (
`ifdef FIFO_WIDE_TO_NARROW_COUNT_EN
      .SLICE_COUNT(sc),
`endif
      .CLK(clk), .RST(rst), .WRITE(write), .DATA_IN(data_in), .FULL(full),
      .READ(read), .DATA_OUT(dout), .EMPTY(empty), .OVERFLOW(ovf), .UNDERFLOW(unf)
   );

   fifo_wide_to_narrow #(.NARROW_WIDTH(8), .RATIO(4), .DEPTH(8), .MSB_FIRST(1)) dut_msb (
`ifdef FIFO_WIDE_TO_NARROW_COUNT_EN
      .SLICE_COUNT(sc_m),
`endif
      .CLK(clk), .RST(rst), .WRITE(write), .DATA_IN(data_in), .FULL(full_m),
      .READ(read), .DATA_OUT(dout_m), .EMPTY(empty_m), .OVERFLOW(ovf_m), .UNDERFLOW(unf_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [31:0] din;
      logic        rd;
      logic        exp_empty;
      logic [7:0]  exp_do;
      logic [7:0]  exp_do_msb;
      logic        exp_full;
      logic        exp_ovf;
      logic        exp_unf;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mkword(input int base);
      return {8'(base + 3), 8'(base + 2), 8'(base + 1), 8'(base)};
   endfunction

   initial begin
      int consumed;
      bit seen_load;
      int wcnt;

      // Single word, both byte orders, then an underflow read
      vecs[0] = '{1'b1, 32'h44332211, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 32'h0,        1'b0, 1'b0, 8'h11, 8'h44, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h22, 8'h33, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h33, 8'h22, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h44, 8'h11, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h44, 8'h11, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h44, 8'h11, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{1'b0, 32'h0,        1'b0, 1'b1, 8'h44, 8'h11, 1'b0, 1'b0, 1'b0};

      rst = 1'b1; write = 1'b0; data_in = '0; read = 1'b0;
      #12;
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_dout", dout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_unf", unf, 0);
`ifdef FIFO_WIDE_TO_NARROW_COUNT_EN
      chk("rst_sc", sc, 0);
`endif
      #1 rst = 1'b0;
      tick();

      // Table-driven single-word sequence
      for (int i = 0; i < 8; i++) begin
         write = vecs[i].wr; data_in = vecs[i].din; read = vecs[i].rd;
         tick();
         $display("vec %0d: wr=%b rd=%b -> empty=%b dout=%h dout_msb=%h unf=%b",
                  i, vecs[i].wr, vecs[i].rd, empty, dout, dout_m, unf);
         chk($sformatf("v%0d_empty", i), empty, vecs[i].exp_empty);
         chk($sformatf("v%0d_dout", i), dout, vecs[i].exp_do);
         chk($sformatf("v%0d_dout_msb", i), dout_m, vecs[i].exp_do_msb);
         chk($sformatf("v%0d_full", i), full, vecs[i].exp_full);
         chk($sformatf("v%0d_ovf", i), ovf, vecs[i].exp_ovf);
         chk($sformatf("v%0d_unf", i), unf, vecs[i].exp_unf);
      end

      // Fill: 9 words (8 in storage + 1 held), then a dropped 10th write
      read = 1'b0;
      for (int i = 0; i < 9; i++) begin
         write = 1'b1; data_in = mkword(4 * i);
         tick();
         $display("fill %0d: din=%h full=%b", i, data_in, full);
         chk($sformatf("fill%0d_full", i), full, (i == 8) ? 1 : 0);
      end
      data_in = 32'hFFFFFFFF;
      tick();
      chk("ovf_pulse", ovf, 1);
      chk("ovf_full", full, 1);
      write = 1'b0;
      tick();
      chk("ovf_clear", ovf, 0);
      chk("full_hold", full, 1);

      // Drain: 36 slices back to back, in order, FULL drops after first word
      for (int k = 0; k < 36; k++) begin
         chk($sformatf("drain%0d_empty", k), empty, 0);
         chk($sformatf("drain%0d_dout", k), dout, 32'(8'(k)));
         chk($sformatf("drain%0d_dout_msb", k), dout_m, 32'(8'(4 * (k / 4) + 3 - (k % 4))));
         read = 1'b1;
         tick();
         chk($sformatf("drain%0d_full", k), full, (k < 3) ? 1 : 0);
      end
      read = 1'b0;
      $display("drain done: empty=%b", empty);
      chk("drain_empty_end", empty, 1);
      chk("drain_no_unf", unf, 0);

      // Streaming: a write every 4th cycle, reads whenever data is present
      consumed = 0; seen_load = 0; wcnt = 0;
      for (int c = 0; c < 100; c++) begin
         if (empty == 1'b0) begin
            seen_load = 1;
            chk($sformatf("stream%0d_dout", consumed), dout, 32'(8'(8'h40 + consumed)));
            consumed++;
            read = 1'b1;
         end else begin
            if (seen_load && consumed < 80) chk($sformatf("stream_gap_c%0d", c), empty, 0);
            read = 1'b0;
         end
         if ((c % 4) == 0 && wcnt < 20) begin
            write = 1'b1; data_in = mkword(8'h40 + 4 * wcnt); wcnt++;
         end else begin
            write = 1'b0;
         end
         tick();
      end
      write = 1'b0; read = 1'b0;
      $display("stream done: consumed=%0d", consumed);
      chk("stream_consumed", consumed, 80);
      chk("stream_empty_end", empty, 1);

      // Reset mid-word with a second word still in storage
      write = 1'b1; data_in = 32'h44332211; tick();
      data_in = 32'h88776655; tick();
      write = 1'b0; read = 1'b1; tick(); tick();
      read = 1'b0;
      chk("mid_dout", dout, 32'h33);
      #1 rst = 1'b1;
      #1;
      $display("async reset: empty=%b dout=%h", empty, dout);
      chk("arst_empty", empty, 1);
      chk("arst_dout", dout, 0);
      chk("arst_dout_msb", dout_m, 0);
      chk("arst_full", full, 0);
      #1 rst = 1'b0;
      write = 1'b1; data_in = 32'hDDCCBBAA; tick();
      write = 1'b0;
      chk("post_rst_empty1", empty, 1);
      tick();
      chk("post_rst_empty2", empty, 0);
      chk("post_rst_first", dout, 32'hAA);
      chk("post_rst_first_msb", dout_m, 32'hDD);
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("post_rst_s%0d", j), dout, 32'(8'(8'hAA + 8'h11 * j)));
         read = 1'b1; tick();
      end
      read = 1'b0;
      chk("post_rst_empty_end", empty, 1);

`ifdef FIFO_WIDE_TO_NARROW_COUNT_EN
      // Slice count: 3 words buffered, one slice read
      chk("sc_zero", sc, 0);
      for (int i = 0; i < 3; i++) begin
         write = 1'b1; data_in = mkword(4 * i); tick();
      end
      write = 1'b0;
      chk("sc_12", sc, 12);
      read = 1'b1; tick();
      read = 1'b0;
      $display("slice count after one read: %0d", sc);
      chk("sc_11", sc, 11);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_wide_to_narrow.md
Name: fifo_wide_to_narrow

Overview:
- Parametrised successor to the fixed 32-to-8 FIFO converter in utils.
- Buffers wide words (RATIO x NARROW_WIDTH bits) in a DEPTH-entry FIFO.
- Emits them as NARROW_WIDTH-bit slices in selectable byte order, first-word-fall-through.
- Sits between 32-bit BRAM FIFO data and byte-wide sinks, e.g. the Ethernet TCP/UDP TX path in the mmc3_eth core.

Parameters:
- NARROW_WIDTH, 8: output slice width in bits.
- RATIO, 4: slices per wide word, >=2; input width is RATIO*NARROW_WIDTH.
- DEPTH, 8: wide-word storage entries; power of two, >=2.
- MSB_FIRST, 0: 0 emits slice 0 (bits NARROW_WIDTH-1:0) first; 1 emits the top slice first.

Ports:
- CLK  in  1  single clock for all logic.
- RST  in  1  asynchronous, active-high reset.
- WRITE  in  1  write strobe for DATA_IN.
- DATA_IN  in  RATIO*NARROW_WIDTH  wide input word.
- FULL  out  1  storage holds DEPTH wide words; writes are dropped while high.
- READ  in  1  consume the current slice.
- DATA_OUT  out  NARROW_WIDTH  current slice, valid while EMPTY=0.
- EMPTY  out  1  no slice available.
- OVERFLOW  out  1  one-cycle pulse when WRITE is asserted while FULL=1.
- UNDERFLOW  out  1  one-cycle pulse when READ is asserted while EMPTY=1.

Behaviour:
- Reset is asynchronous, active-high; all state is cleared the same way whenever RST asserts, including mid-word.
- Reset values:
  - EMPTY=1, FULL=0, DATA_OUT=0, OVERFLOW=0, UNDERFLOW=0.
  - Storage pointers, storage count and slice index all 0.
  - Holding register marked invalid.
  - A partially emitted wide word is discarded; its remaining slices never appear after reset.
- Structure:
  - Storage is a circular buffer with wr_ptr/rd_ptr of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
  - Output stage is one wide holding register, a valid flag and a slice index of log2(RATIO) bits (RATIO need not be a power of two).
  - Total capacity is DEPTH+1 wide words.
- Write:
  - Accepted on a CLK edge when WRITE=1 and FULL=0.
  - FULL is registered, FULL = (count==DEPTH).
  - No write-through when full: WRITE with FULL=1 is ignored even if a storage pop happens on the same edge.
- Output stage, two states:
  - IDLE (holding register invalid): loads the head word when storage is non-empty.
  - SERVE (holding register valid): serves slices.
  - Load and pop happen on the same edge.
- Slice ordering:
  - Slice k has bits (k+1)*NARROW_WIDTH-1 : k*NARROW_WIDTH.
  - MSB_FIRST=0 emits k = 0..RATIO-1; MSB_FIRST=1 emits k = RATIO-1..0.
- Read:
  - READ=1 with EMPTY=0 advances the index on the edge.
  - On the last slice, if storage is non-empty, the next word loads on the same edge. No bubble; EMPTY stays 0.
  - If storage is empty on the last slice, the stage returns to IDLE and EMPTY goes to 1.
- Latency:
  - WRITE sampled on edge k into an empty block: word lands in storage at edge k.
  - Word loads into the holding register at edge k+1; EMPTY=0 after edge k+1.
- Simultaneous WRITE and storage pop on one edge: count is unchanged, both pointers advance.
- EMPTY equals NOT(holding valid) and is registered.
- DATA_OUT is a mux of the holding register by index; it holds its value while EMPTY=1.
- Boundary conditions:
  - Full storage with the holding register valid: FULL=1.
  - A final-slice read frees a storage entry; FULL deasserts after that edge.
  - OVERFLOW and UNDERFLOW are registered pulses, asserted the cycle after the offending edge.
  - Pointer and count state is unaffected by dropped writes and by underflow reads.

Optional Feature:
- Macro FIFO_WIDE_TO_NARROW_COUNT_EN.
- Defined: adds output SLICE_COUNT, width log2((DEPTH+1)*RATIO)+1.
  - Value is storage_count*RATIO + (holding valid ? RATIO-index : 0).
  - Registered, updated every edge, 0 at reset.
  - Usable as a TX length field.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Defaults; write 0x44332211 once, then hold READ=1 -> EMPTY drops 2 edges after the write; DATA_OUT = 0x11, 0x22, 0x33, 0x44 on consecutive cycles; EMPTY=1 after the 4th read; UNDERFLOW pulses if READ is held a 5th cycle.
- MSB_FIRST=1, same word -> 0x44, 0x33, 0x22, 0x11.
- Fill: write 9 words 0..8 with READ=0 -> FULL=1 after the 9th accepted write; a 10th write gives an OVERFLOW pulse and no data change; a full drain yields 36 slices, words 0..8 in order with no gaps.
- Continuous streaming: write every 4th cycle, read every cycle -> EMPTY never asserts after the first load; pointer wrap at DEPTH is verified over 20 words.
- Reset mid-word: after 2 of 4 slices read, pulse RST asynchronously between edges -> outputs go to reset values immediately; a next write 0xDDCCBBAA emits 0xAA first.
- With FIFO_WIDE_TO_NARROW_COUNT_EN: 3 words written, 1 slice read -> SLICE_COUNT=11; compile without the macro and confirm tests 1-5 pass unchanged.
